box_drawer: RTL



---
 rtl/game_pkg.sv | 19 +
 rtl/pixel_scan_counter.sv | 30 +++
 rtl/box_drawer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants and draw-FSM state type, used by the box/pipe drawers and collision logic.
package game_pkg;

  localparam logic [7:0] SCREEN_W = 8'd160;
  localparam logic [6:0] SCREEN_H = 7'd120;

  localparam logic [2:0] COL_BG  = 3'b000;
  localparam logic [2:0] COL_BOX = 3'b110;
  localparam logic [2:0] COL_FLY = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    ERASE,
    DRAW,
    DONE
  } draw_state_t;

endpackage

// File: rtl/pixel_scan_counter.sv
// Raster scan over a 2^LOG2 square: one pixel offset per enabled cycle, row-major.
// cnt updates one cycle after enable; start clears to pixel 0 and takes priority.
module pixel_scan_counter #(
  parameter int LOG2 = 2
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                enable,
  output logic [2*LOG2-1:0]   cnt,
  output logic [LOG2-1:0]     dx,
  output logic [LOG2-1:0]     dy,
  output logic                last
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign dx   = cnt[LOG2-1:0];
  assign dy   = cnt[2*LOG2-1:LOG2];
  assign last = &cnt;

endmodule

// File: rtl/box_drawer.sv
// Per tick: erase the box at its old row, redraw at the new row; 35/19/3 cycles tick-to-frame_done.
// No backpressure: one pixel per cycle; one tick may queue while busy, further ticks are dropped.
module box_drawer
  import game_pkg::*;
#(
  parameter logic [7:0] BOX_X      = 8'd20,
  parameter int         BOX_LOG2   = 2,
  parameter logic [2:0] BOX_COLOUR = game_pkg::COL_BOX,
  parameter logic [2:0] FLY_COLOUR = game_pkg::COL_FLY,
  parameter logic [2:0] BG_COLOUR  = game_pkg::COL_BG,
  parameter logic [6:0] SCREEN_H   = game_pkg::SCREEN_H
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tick,
  input  logic [6:0] y_coordinate,
  input  logic       flying,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done
);

  draw_state_t state;

  logic [6:0] new_y, old_y;
  logic [2:0] new_col, old_col;
  logic       old_valid;
  logic       pending;
  logic       scan_wrap;

  logic [2*BOX_LOG2-1:0] cnt;
  logic [BOX_LOG2-1:0]   dx, dy;
  logic                  last;

  logic       start;
  logic       scan_en;
  logic       px_on;
  logic [6:0] px_row;
  logic [2:0] px_col;
  logic [2:0] lat_col;
  logic       skip;
  logic [7:0] row_sum;
  logic [7:0] col_sum;
  logic       visible;

  pixel_scan_counter #(.LOG2(BOX_LOG2)) u_scan (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .enable (scan_en),
    .cnt    (cnt),
    .dx     (dx),
    .dy     (dy),
    .last   (last)
  );

  // Clear the counter only if an aborted pass left it mid-scan.
  assign start = (state == IDLE) && (cnt != '0);

  // Outputs are registered one pixel ahead: the counter indexes the pixel being
  // loaded into vga_*, so the phase change is decided when scan_wrap flags the wrap.
  always_comb begin
    lat_col = flying ? FLY_COLOUR : BOX_COLOUR;
    skip    = old_valid && (y_coordinate == old_y) && (lat_col == old_col);
    px_on   = 1'b0;
    scan_en = 1'b0;
    px_row  = old_y;
    px_col  = BG_COLOUR;
    case (state)
      LATCH: begin
        if (!skip) begin
          px_on   = 1'b1;
          scan_en = 1'b1;
          if (!old_valid) begin
            px_row = y_coordinate;
            px_col = lat_col;
          end
        end
      end
      ERASE: begin
        px_on   = 1'b1;
        scan_en = 1'b1;
        if (scan_wrap) begin
          px_row = new_y;
          px_col = new_col;
        end
      end
      DRAW: begin
        if (!scan_wrap) begin
          px_on   = 1'b1;
          scan_en = 1'b1;
          px_row  = new_y;
          px_col  = new_col;
        end
      end
      default: ;
    endcase
    row_sum = 8'(px_row) + 8'(dy);
    col_sum = BOX_X + 8'(dx);
    visible = row_sum < {1'b0, SCREEN_H};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      plot       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      new_y      <= '0;
      new_col    <= '0;
      old_y      <= '0;
      old_col    <= '0;
      old_valid  <= 1'b0;
      pending    <= 1'b0;
      scan_wrap  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      plot       <= px_on && visible;
      vga_x      <= col_sum;
      vga_y      <= row_sum[6:0];
      vga_colour <= px_col;
      scan_wrap  <= scan_en && last;

      if (state == IDLE) begin
        pending <= 1'b0;
      end else if (tick) begin
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tick || pending) begin
            state <= LATCH;
            busy  <= 1'b1;
          end
        end
        LATCH: begin
          new_y   <= y_coordinate;
          new_col <= lat_col;
          if (skip)           state <= DONE;
          else if (old_valid) state <= ERASE;
          else                state <= DRAW;
        end
        ERASE: begin
          if (scan_wrap) state <= DRAW;
        end
        DRAW: begin
          if (scan_wrap) state <= DONE;
        end
        DONE: begin
          old_y      <= new_y;
          old_col    <= new_col;
          old_valid  <= 1'b1;
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
